// File: rtl/mips_dmem_ctrl.sv
// Data memory and MMIO controller sitting on the MIPS memory port.
// Latency: one cycle; read data is registered and valid the cycle after mem_read_en.
// Backpressure: the CPU side never stalls; TX is valid/ready, and a push into a full FIFO is dropped and flagged.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              global enable for writes and read-data updates
//   mem_write_en    byte-lane write enables (bit3 = data[31:24], big-endian offset 0)
//   mem_read_en     read request
//   mem_addr        byte address
//   mem_write_data  store data (byte stores are replicated across lanes)
//   mem_read_data   registered 32-bit read word
//   tx_data         head byte of TX FIFO
//   tx_valid        TX FIFO non-empty
//   tx_ready        consumer accepts the head byte
//
// Build option: define DMEM_CYCLE_COUNTER_EN to implement the CYCLE register
// at MMIO offset 0x0; without it that offset reads 0.
module mips_dmem_ctrl #(
  parameter int DEPTH_LOG2    = 12,
  parameter int TX_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [3:0]  mem_write_en,
  input  logic        mem_read_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int WORDS    = 1 << DEPTH_LOG2;
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int CNT_W    = TX_DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TX_DEPTH);

  // Address decode
  logic                  ram_sel;
  logic                  mmio_sel;
  logic [1:0]            reg_sel;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  unused_addr_bits;

  // RAM sits at the bottom of the map: every bit above the word index must be zero.
  assign ram_sel          = (mem_addr >> (DEPTH_LOG2 + 2)) == 32'd0;
  assign mmio_sel         = mem_addr[31:4] == 28'hFFFF000;
  assign reg_sel          = mem_addr[3:2];
  assign ram_idx          = mem_addr[DEPTH_LOG2+1:2];
  // Byte offset is irrelevant: accesses are word-wide with lane enables.
  assign unused_addr_bits = ^mem_addr[1:0];

  // Word RAM, no reset so it maps onto block memory
  logic [31:0] ram [WORDS];

  always_ff @(posedge clk) begin
    if (en && ram_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_en[i]) ram[ram_idx][i*8 +: 8] <= mem_write_data[i*8 +: 8];
      end
    end
  end

  // TX FIFO
  logic [7:0]               tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] wr_ptr;
  logic [TX_DEPTH_LOG2-1:0] rd_ptr;
  logic [CNT_W-1:0]         tx_count;
  logic                     overflow;
  logic                     tx_full;
  logic                     tx_empty;
  logic                     push_req;
  logic                     push_ok;
  logic                     pop;
  logic                     ovf_clr;
  logic                     ovf_set;

  assign tx_full  = tx_count == FULL_CNT;
  assign tx_empty = tx_count == '0;
  assign tx_valid = !tx_empty;
  // Gating keeps tx_data at 0 out of reset even though storage is not reset.
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[rd_ptr];

  assign push_req = en && mmio_sel && (reg_sel == 2'd1) && (|mem_write_en);
  assign pop      = tx_valid && tx_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!tx_full || pop);
  assign ovf_set  = push_req && tx_full && !pop;
  assign ovf_clr  = en && mmio_sel && (reg_sel == 2'd2) && mem_write_en[0] && mem_write_data[2];

  always_ff @(posedge clk) begin
    if (push_ok) tx_mem[wr_ptr] <= mem_write_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
      // Set has priority over a clear issued in the same cycle.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // Cycle counter
  logic [31:0] cycle_val;

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt;

  // Free-running regardless of en so software can time stalled periods too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + 32'd1;
  end

  assign cycle_val = cycle_cnt;
`else
  assign cycle_val = 32'd0;
`endif

  // Read path
  logic [31:0] rd_word;

  always_comb begin
    rd_word = 32'd0;
    if (ram_sel) begin
      rd_word = ram[ram_idx];
    end else if (mmio_sel) begin
      case (reg_sel)
        2'd0:    rd_word = cycle_val;
        2'd1:    rd_word = {24'd0, tx_data};
        2'd2:    rd_word = {29'd0, overflow, tx_empty, tx_full};
        default: rd_word = 32'd0;
      endcase
    end
  end

  // Sampling the RAM here alongside the write gives read-first behaviour on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     mem_read_data <= 32'd0;
    else if (en && mem_read_en)  mem_read_data <= rd_word;
  end

endmodule

// File: tb/tb_mips_dmem_ctrl.sv
module tb_mips_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int errors = 0;

  mips_dmem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .mem_write_en   (mem_write_en),
    .mem_read_en    (mem_read_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] TXD  = 32'hFFFF0004;
  localparam logic [31:0] STAT = 32'hFFFF0008;
  localparam logic [31:0] CYC  = 32'hFFFF0000;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic e, input logic [3:0] w, input logic r,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic c, input logic [31:0] x, input string n);
    vec_t v;
    v.en = e; v.we = w; v.re = r; v.addr = a; v.wdata = d; v.chk = c; v.exp = x; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic r,
                       input logic [31:0] a, input logic [31:0] d);
    en = e; mem_write_en = w; mem_read_en = r; mem_addr = a; mem_write_data = d;
  endtask

  // One clock: inputs set at negedge, DUT samples at posedge, outputs checked at next negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic read_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    drive(1'b1, 4'b0000, 1'b1, a, 32'h0);
    step();
    check(name, mem_read_data, exp);
  endtask

  task automatic push(input logic [7:0] b);
    drive(1'b1, 4'b1111, 1'b0, TXD, {4{b}});
    step();
  endtask

  initial begin
    logic [31:0] c1;
    logic [31:0] c2;

    rst = 1'b1;
    tx_ready = 1'b0;
    drive(1'b0, 4'b0000, 1'b0, 32'h0, 32'h0);
    #12;
    check("reset_rdata", mem_read_data, 32'h0);
    check("reset_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("reset_tx_data", {24'd0, tx_data}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // RAM and decode vectors
    vecs.push_back(mk(1, 4'b1111, 0, 32'h10, 32'h12345678, 0, 0, "word_store"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'h10, 32'h0, 1, 32'h12345678, "word_read"));
    vecs.push_back(mk(1, 4'b0010, 0, 32'h12, 32'hABABABAB, 0, 0, "byte_store"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'h10, 32'h0, 1, 32'h1234AB78, "byte_merge"));
    vecs.push_back(mk(1, 4'b1111, 0, 32'h20, 32'hCAFEF00D, 0, 0, "prefill_20"));
    vecs.push_back(mk(0, 4'b1111, 1, 32'h20, 32'hDEADBEEF, 1, 32'h1234AB78, "en0_hold"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'h20, 32'h0, 1, 32'hCAFEF00D, "en0_no_write"));
    vecs.push_back(mk(1, 4'b1111, 1, 32'h20, 32'h11112222, 1, 32'hCAFEF00D, "read_first"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'h20, 32'h0, 1, 32'h11112222, "after_collision"));
    vecs.push_back(mk(1, 4'b0000, 0, 32'h10, 32'h0, 1, 32'h11112222, "re0_hold"));
    vecs.push_back(mk(1, 4'b0001, 0, 32'h13, 32'hCDCDCDCD, 0, 0, "lane0_store"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'h10, 32'h0, 1, 32'h1234ABCD, "lane0_merge"));
    vecs.push_back(mk(1, 4'b1111, 0, 32'h4010, 32'hFFFFFFFF, 0, 0, "unmapped_wr"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'h10, 32'h0, 1, 32'h1234ABCD, "no_alias"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'h4010, 32'h0, 1, 32'h0, "unmapped_rd"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'h40000000, 32'h0, 1, 32'h0, "rd_40000000"));
    vecs.push_back(mk(1, 4'b1111, 0, 32'hFFFF000C, 32'hFFFFFFFF, 0, 0, "rsvd_wr"));
    vecs.push_back(mk(1, 4'b0000, 1, 32'hFFFF000C, 32'h0, 1, 32'h0, "rsvd_rd"));
    vecs.push_back(mk(1, 4'b0000, 1, STAT, 32'h0, 1, 32'h2, "status_idle"));

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      step();
      if (vecs[i].chk) check(vecs[i].name, mem_read_data, vecs[i].exp);
    end

    // Overflow: 9 pushes into an 8-deep FIFO with no consumer
    for (int b = 1; b <= 9; b++) push(8'(b));
    read_chk(STAT, 32'h5, "status_full_ovf");
    read_chk(TXD, 32'h01, "txdata_peek");
    check("peek_no_pop", {24'd0, tx_data}, 32'h01);
    tx_ready = 1'b1;
    drive(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    for (int b = 1; b <= 8; b++) begin
      check($sformatf("drain_valid_%0d", b), {31'd0, tx_valid}, 32'h1);
      check($sformatf("drain_data_%0d", b), {24'd0, tx_data}, 32'(b));
      step();
    end
    check("drain_empty", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    read_chk(STAT, 32'h6, "status_empty_ovf");
    drive(1'b1, 4'b0001, 1'b0, STAT, 32'h4);
    step();
    read_chk(STAT, 32'h2, "status_cleared");

    // Push into a full FIFO while it pops in the same cycle
    for (int b = 0; b < 8; b++) push(8'(8'h11 + b));
    tx_ready = 1'b1;
    push(8'h55);
    tx_ready = 1'b0;
    read_chk(STAT, 32'h1, "full_push_pop_status");
    tx_ready = 1'b1;
    drive(1'b1, 4'b0000, 1'b0, 32'h0, 32'h0);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("pp_valid_%0d", b), {31'd0, tx_valid}, 32'h1);
      check($sformatf("pp_data_%0d", b), {24'd0, tx_data}, (b == 7) ? 32'h55 : 32'(8'h12 + b));
      step();
    end
    check("pp_empty", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Push into an empty FIFO with tx_ready already high: no pop that cycle
    tx_ready = 1'b1;
    push(8'h77);
    check("empty_push_valid", {31'd0, tx_valid}, 32'h1);
    check("empty_push_data", {24'd0, tx_data}, 32'h77);
    idle();
    check("empty_push_drained", {31'd0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // Cycle counter
`ifdef DMEM_CYCLE_COUNTER_EN
    drive(1'b1, 4'b0000, 1'b1, CYC, 32'h0);
    step();
    c1 = mem_read_data;
    repeat (5) @(posedge clk);
    @(negedge clk);
    c2 = mem_read_data;
    check("cycle_delta", c2 - c1, 32'd5);
`else
    read_chk(CYC, 32'h0, "cycle_absent");
    c1 = 32'h0;
    c2 = 32'h0;
`endif
    drive(1'b1, 4'b1111, 1'b0, CYC, 32'hFFFFFFFF);
    step();

    // Reset in the middle of a drain
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    read_chk(32'h10, 32'h1234ABCD, "pre_reset_read");
    tx_ready = 1'b1;
    idle();
    rst = 1'b1;
    #1;
    check("async_tx_valid", {31'd0, tx_valid}, 32'h0);
    check("async_rdata", mem_read_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b0;
    read_chk(STAT, 32'h2, "post_reset_status");
    read_chk(32'h10, 32'h1234ABCD, "ram_retained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
